// File: rtl/adc_buf_pkg.sv
// Shared definitions for the ADC capture buffer: frame FSM states, header layout
// and the header byte lookup used by the frame scheduler.
package adc_buf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_HDR,
        ST_PAYLOAD,
        ST_GAP
    } fsm_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         HDR_LEN   = 4;
    localparam int         HDR_IDX_W = $clog2(HDR_LEN);

    typedef logic [HDR_IDX_W-1:0] hdr_idx_t;

    // Header layout: sync, channel, sequence high byte, sequence low byte.
    function automatic logic [7:0] hdr_byte(input hdr_idx_t idx, input logic ch,
                                            input logic [15:0] frame_seq);
        case (idx)
            hdr_idx_t'(0): hdr_byte = SYNC_BYTE;
            hdr_idx_t'(1): hdr_byte = {7'b0, ch};
            hdr_idx_t'(2): hdr_byte = frame_seq[15:8];
            default:       hdr_byte = frame_seq[7:0];
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the grant is the last-served register, updated
// in the single cycle arb_en is high. Channel 0 wins the first contested round.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       arb_en,
    output logic       grant
);

    logic last_reg;
    logic pick;

    always_comb begin
        pick = ~last_reg;
        if (req == 2'b01) begin
            pick = 1'b0;
        end else if (req == 2'b10) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_reg <= 1'b1;
        end else if (arb_en) begin
            last_reg <= pick;
        end
    end

    assign grant = last_reg;

endmodule

// File: rtl/frame_scheduler.sv
// Frames two ADC channel FIFOs into a header+payload byte stream for the UDP
// transmitter, alternating channels round-robin with a fixed gap after each frame.
module frame_scheduler
    import adc_buf_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 1024,
    parameter int GAP_CYCLES    = 12
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [1:0]  ch_ready,
    input  logic [1:0]  ch_empty,
    output logic [1:0]  ch_rd_en,
    input  logic [7:0]  ch0_dout,
    input  logic [7:0]  ch1_dout,
    input  logic        tx_busy,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic [15:0] seq,
    output logic        underflow,
    output logic        busy
);

    localparam int BYTE_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(PAYLOAD_BYTES - 1);
    localparam logic [BYTE_W-1:0] PRE_LAST  = BYTE_W'(PAYLOAD_BYTES - 2);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    fsm_state_t        state_reg;
    logic              armed_reg;
    logic              busy_reg;
    logic              tx_valid_reg;
    logic              tx_last_reg;
    logic [7:0]        tx_hdr_reg;
    logic              payload_reg;
    logic [1:0]        rd_en_reg;
    logic [15:0]       seq_reg;
    logic [15:0]       seq_latch_reg;
    hdr_idx_t          hdr_cnt_reg;
    logic [BYTE_W-1:0] byte_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic              underflow_reg;

    logic              grant;
    logic [1:0]        sel_mask;
    logic [1:0]        empty_hit;
    logic              start_frame;

    rr_arb2 u_arb (
        .clk    (clk),
        .rstn   (rstn),
        .req    (ch_ready),
        .arb_en (state_reg == ST_ARB),
        .grant  (grant)
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        assign sel_mask[gi]  = (grant == 1'(gi));
        assign empty_hit[gi] = rd_en_reg[gi] & ch_empty[gi];
    end

    // armed_reg holds off frame starts until the second edge after reset release.
    assign start_frame = armed_reg && en && !tx_busy && (ch_ready != 2'b00);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            armed_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            tx_valid_reg  <= 1'b0;
            tx_last_reg   <= 1'b0;
            tx_hdr_reg    <= 8'h00;
            payload_reg   <= 1'b0;
            rd_en_reg     <= 2'b00;
            seq_reg       <= 16'h0000;
            seq_latch_reg <= 16'h0000;
            hdr_cnt_reg   <= '0;
            byte_cnt_reg  <= '0;
            gap_cnt_reg   <= '0;
            underflow_reg <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
            if (empty_hit != 2'b00) begin
                underflow_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start_frame) begin
                        state_reg <= ST_ARB;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    seq_latch_reg <= seq_reg;
                    hdr_cnt_reg   <= '0;
                    tx_valid_reg  <= 1'b1;
                    tx_hdr_reg    <= hdr_byte(hdr_idx_t'(0), 1'b0, seq_reg);
                    state_reg     <= ST_HDR;
                end
                ST_HDR: begin
                    if (hdr_cnt_reg == hdr_idx_t'(HDR_LEN - 1)) begin
                        state_reg    <= ST_PAYLOAD;
                        byte_cnt_reg <= '0;
                        tx_hdr_reg   <= 8'h00;
                        payload_reg  <= 1'b1;
                    end else begin
                        hdr_cnt_reg <= hdr_cnt_reg + 1'b1;
                        tx_hdr_reg  <= hdr_byte(hdr_idx_t'(hdr_cnt_reg + 1'b1), grant,
                                                seq_latch_reg);
                        // First read is issued on the last header byte so data lines up.
                        if (hdr_cnt_reg == hdr_idx_t'(HDR_LEN - 2)) begin
                            rd_en_reg <= sel_mask;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_cnt_reg == LAST_BYTE) begin
                        state_reg    <= ST_GAP;
                        gap_cnt_reg  <= '0;
                        tx_valid_reg <= 1'b0;
                        tx_last_reg  <= 1'b0;
                        payload_reg  <= 1'b0;
                        rd_en_reg    <= 2'b00;
                        seq_reg      <= seq_reg + 16'd1;
                    end else begin
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        if (byte_cnt_reg == PRE_LAST) begin
                            tx_last_reg <= 1'b1;
                            rd_en_reg   <= 2'b00;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Payload bytes come straight from the FIFO, which presents data the cycle after a read.
    always_comb begin
        tx_data = tx_hdr_reg;
        if (payload_reg) begin
            tx_data = grant ? ch1_dout : ch0_dout;
        end
    end

    assign tx_valid  = tx_valid_reg;
    assign tx_last   = tx_last_reg;
    assign ch_rd_en  = rd_en_reg;
    assign seq       = seq_reg;
    assign underflow = underflow_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_frame_scheduler.sv
// Randomized and directed bench for frame_scheduler against a frame-level timing model.
module tb_frame_scheduler;

    localparam int PB   = 8;
    localparam int GC   = 4;
    localparam int SPAN = 1 + 4 + PB + GC;   // cycles with busy high, ARB through GAP

    logic        clk = 1'b0;
    logic        rstn, en, tx_busy;
    logic [1:0]  ch_ready, ch_empty, ch_rd_en;
    logic [7:0]  ch0_dout = 8'h00, ch1_dout = 8'h00, tx_data;
    logic        tx_valid, tx_last, underflow, busy;
    logic [15:0] seq;

    frame_scheduler #(.PAYLOAD_BYTES(PB), .GAP_CYCLES(GC)) dut (
        .clk(clk), .rstn(rstn), .en(en), .ch_ready(ch_ready), .ch_empty(ch_empty),
        .ch_rd_en(ch_rd_en), .ch0_dout(ch0_dout), .ch1_dout(ch1_dout), .tx_busy(tx_busy),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .seq(seq),
        .underflow(underflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- channel FIFO models ----------------
    logic [7:0] q0[$], q1[$], s0[$], s1[$];
    logic [1:0] force_empty = 2'b00;

    task automatic update_flags();
        ch_ready[0] = (q0.size() >= PB);
        ch_ready[1] = (q1.size() >= PB);
        ch_empty[0] = (q0.size() == 0) || force_empty[0];
        ch_empty[1] = (q1.size() == 0) || force_empty[1];
    endtask

    task automatic push(input int ch, input logic [7:0] v);
        if (ch == 0) begin q0.push_back(v); s0.push_back(v); end
        else         begin q1.push_back(v); s1.push_back(v); end
        update_flags();
    endtask

    task automatic clear_fifos();
        q0.delete(); q1.delete(); s0.delete(); s1.delete();
        force_empty = 2'b00;
        update_flags();
    endtask

    always begin
        logic [7:0] v;
        @(posedge clk);
        if (ch_rd_en[0]) begin
            v = (q0.size() > 0) ? q0.pop_front() : 8'hEE;
            ch0_dout <= v;
        end
        if (ch_rd_en[1]) begin
            v = (q1.size() > 0) ? q1.pop_front() : 8'hEE;
            ch1_dout <= v;
        end
        #1 update_flags();
    end

    // ---------------- frame-level reference model ----------------
    int          cyc;
    bit          m_active, m_pending, m_armed, m_last, m_ch, m_uf;
    int          m_start;
    logic [15:0] m_seq, m_fseq;
    logic [7:0]  m_pay[PB];

    logic [7:0]  tx_log[$], hdr_ch_log[$], hdr_seq_log[$];
    int          gap_log[$];
    int          rd0_cnt, fb, gap_run;
    bit          in_gap;

    always @(negedge clk) begin
        int         d;
        logic [7:0] e_data;
        logic [1:0] e_rd;
        bit         e_valid, e_last, e_busy;
        if (!rstn) begin
            chk("rst_tx_valid", tx_valid, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_tx_last", tx_last, 0);
            chk("rst_rd_en", ch_rd_en, 0);
            chk("rst_seq", seq, 0);
            chk("rst_busy", busy, 0);
            chk("rst_underflow", underflow, 0);
            cyc = -1; m_active = 0; m_pending = 0; m_armed = 0;
            m_last = 1; m_uf = 0; m_seq = 16'h0000; fb = 0; in_gap = 0;
        end else begin
            cyc++;
            if (m_pending && cyc == m_start) begin
                if (ch_ready == 2'b01)      m_ch = 0;
                else if (ch_ready == 2'b10) m_ch = 1;
                else                        m_ch = !m_last;
                m_last = m_ch;
                for (int i = 0; i < PB; i++) begin
                    if (m_ch == 0) m_pay[i] = (s0.size() > 0) ? s0.pop_front() : 8'hEE;
                    else           m_pay[i] = (s1.size() > 0) ? s1.pop_front() : 8'hEE;
                end
                m_fseq = m_seq; m_active = 1; m_pending = 0;
            end
            d = m_active ? (cyc - m_start) : -1;
            if (d == 5 + PB) m_seq = m_seq + 16'd1;
            e_valid = (d >= 1) && (d <= 4 + PB);
            e_last  = (d == 4 + PB);
            e_busy  = m_active && (d < SPAN);
            e_rd    = (d >= 4 && d <= PB + 3) ? (m_ch ? 2'b10 : 2'b01) : 2'b00;
            if (d == 1)                     e_data = 8'hA5;
            else if (d == 2)                e_data = {7'b0, m_ch};
            else if (d == 3)                e_data = m_fseq[15:8];
            else if (d == 4)                e_data = m_fseq[7:0];
            else if (d >= 5 && d <= 4 + PB) e_data = m_pay[d-5];
            else                            e_data = 8'h00;
            chk("tx_valid", tx_valid, e_valid);
            chk("tx_data", tx_data, e_data);
            chk("tx_last", tx_last, e_last);
            chk("ch_rd_en", ch_rd_en, e_rd);
            chk("seq", seq, m_seq);
            chk("busy", busy, e_busy);
            chk("underflow", underflow, m_uf);
            if ((e_rd & ch_empty) != 2'b00) m_uf = 1;
            if (!m_active && !m_pending && m_armed && en && !tx_busy && ch_ready != 2'b00) begin
                m_pending = 1;
                m_start   = cyc + 1;
            end
            if (m_active && d >= SPAN - 1) m_active = 0;
            m_armed = 1;

            if (tx_valid) begin
                tx_log.push_back(tx_data);
                if (fb == 1) hdr_ch_log.push_back(tx_data);
                if (fb == 3) hdr_seq_log.push_back(tx_data);
                fb++;
                if (tx_last) begin fb = 0; in_gap = 1; gap_run = 0; end
            end else if (in_gap) begin
                if (busy) gap_run++;
                else begin gap_log.push_back(gap_run); in_gap = 0; end
            end
            if (ch_rd_en[0]) rd0_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        tx_log.delete(); hdr_ch_log.delete(); hdr_seq_log.delete(); gap_log.delete();
        rd0_cnt = 0;
    endtask

    task automatic do_reset();
        step();
        rstn = 1'b0;
        clear_fifos();
        cycles(2);
        rstn = 1'b1;
    endtask

    task automatic wait_d(input int target);
        bit hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (m_active && (cyc - m_start) == target) hit = 1;
        end
        chk("reach_frame_offset", hit, 1);
        step();
    endtask

    task automatic wait_hdrs(input int n);
        bit hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            step();
            if (hdr_ch_log.size() >= n) hit = 1;
        end
        chk("reach_frame_count", hit, 1);
    endtask

    logic [7:0] exp34 [12] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11,
                               8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    logic [7:0] exp_ch3 [3] = '{8'h00, 8'h01, 8'h00};

    initial begin
        rstn = 1'b0; en = 1'b0; tx_busy = 1'b0;
        update_flags();
        cycles(3);
        rstn = 1'b1;

        // Single channel-0 frame with known payload
        clear_logs();
        for (int i = 0; i < PB; i++) push(0, 8'(8'h10 + i));
        en = 1'b1;
        cycles(30);
        chk("f1_len", tx_log.size(), 12);
        if (tx_log.size() == 12)
            for (int i = 0; i < 12; i++) chk("f1_byte", tx_log[i], exp34[i]);
        chk("f1_rd0_pulses", rd0_cnt, 8);
        chk("f1_seq_after", seq, 16'd1);

        // Both channels ready for three frames
        do_reset();
        clear_logs();
        for (int i = 0; i < 3 * PB; i++) begin push(0, 8'($urandom)); push(1, 8'($urandom)); end
        en = 1'b1;
        wait_hdrs(3);
        en = 1'b0;
        cycles(30);
        chk("rr_frames", hdr_ch_log.size(), 3);
        if (hdr_ch_log.size() >= 3)
            for (int i = 0; i < 3; i++) begin
                chk("rr_channel", hdr_ch_log[i], exp_ch3[i]);
                chk("rr_seq_lo", hdr_seq_log[i], i);
            end
        chk("rr_gaps", gap_log.size() >= 2, 1);
        if (gap_log.size() >= 2) begin
            chk("gap_len0", gap_log[0], GC);
            chk("gap_len1", gap_log[1], GC);
        end

        // Transmitter busy holds off the frame
        do_reset();
        clear_logs();
        tx_busy = 1'b1;
        for (int i = 0; i < PB; i++) push(0, 8'($urandom));
        en = 1'b1;
        cycles(10);
        chk("hold_busy", busy, 0);
        chk("hold_valid", tx_valid, 0);
        tx_busy = 1'b0;
        @(negedge clk); chk("rel_idle_busy", busy, 0);
        @(negedge clk); chk("rel_arb_busy", busy, 1); chk("rel_arb_valid", tx_valid, 0);
        @(negedge clk); chk("rel_hdr_valid", tx_valid, 1); chk("rel_hdr_sync", tx_data, 8'hA5);
        cycles(25);

        // en dropped mid-payload: frame completes, nothing follows
        clear_logs();
        for (int i = 0; i < 2 * PB; i++) push(0, 8'($urandom));
        wait_d(7);
        en = 1'b0;
        cycles(40);
        chk("endrop_bytes", tx_log.size(), 12);
        chk("endrop_frames", hdr_ch_log.size(), 1);
        chk("endrop_idle", busy, 0);

        // Underflow is sticky across later frames
        clear_logs();
        for (int i = 0; i < 2 * PB; i++) push(0, 8'($urandom));
        en = 1'b1;
        wait_d(6);
        force_empty[0] = 1'b1; update_flags();
        step();
        force_empty[0] = 1'b0; update_flags();
        wait_hdrs(3);
        cycles(25);
        chk("uf_sticky", underflow, 1);
        en = 1'b0;
        do_reset();
        chk("uf_cleared", underflow, 0);

        // Reset pulsed mid-payload of the second frame
        clear_logs();
        for (int i = 0; i < 2 * PB; i++) push(0, 8'($urandom));
        en = 1'b1;
        cycles(20);
        wait_d(9);
        #2 rstn = 1'b0;
        #1;
        chk("async_valid", tx_valid, 0);
        chk("async_data", tx_data, 0);
        chk("async_rd_en", ch_rd_en, 0);
        chk("async_seq", seq, 0);
        chk("async_busy", busy, 0);
        clear_fifos();
        cycles(2);
        rstn = 1'b1;
        clear_logs();
        for (int i = 0; i < PB; i++) begin push(0, 8'($urandom)); push(1, 8'($urandom)); end
        cycles(45);
        chk("post_rst_frames", hdr_ch_log.size(), 2);
        if (hdr_ch_log.size() >= 2) begin
            chk("post_rst_ch", hdr_ch_log[0], 0);
            chk("post_rst_seq", hdr_seq_log[0], 0);
            chk("post_rst_ch2", hdr_ch_log[1], 1);
        end

        // Random traffic, enable and transmitter back-pressure
        for (int it = 0; it < 60; it++) begin
            int ch, n, len;
            ch = $urandom_range(0, 1);
            n  = $urandom_range(4, 16);
            if ((ch == 0 ? q0.size() : q1.size()) < 40)
                for (int i = 0; i < n; i++) push(ch, 8'($urandom));
            en  = ($urandom_range(0, 9) != 0);
            len = $urandom_range(3, 25);
            for (int c = 0; c < len; c++) begin
                tx_busy = ($urandom_range(0, 3) == 0);
                step();
            end
        end
        en = 1'b1;
        tx_busy = 1'b0;
        cycles(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
